cnt_cascade: RTL and testbench

Parametrised, fully synchronous multi-digit counter. Each digit counts modulo `MODULUS`, and the digits are cascaded through an internal carry/borrow chain. Adds up/down counting, synchronous parallel load, count enable and a terminal-count output. It serves as the general counter for the counter and timer designs, and covers binary (`MODULUS`=16) and BCD (`MODULUS`=10) use from one source.

---
 rtl/cnt_pkg.sv | 14 +
 rtl/cnt_digit.sv | 45 ++++
 rtl/cnt_cascade.sv | 49 ++++
 tb/tb_cnt_cascade.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared helpers for the cascaded modulo counter: per-digit terminal value
// and the configuration legality test used at elaboration.
package cnt_pkg;

   function automatic int term_val(input logic up, input int modulus);
      return up ? (modulus - 1) : 0;
   endfunction

   function automatic logic cfg_legal(input int digits, input int dig_w, input int modulus);
      return (digits >= 1) && (dig_w >= 1) && (dig_w <= 30) &&
             (modulus >= 2) && (modulus <= (1 << dig_w));
   endfunction

endpackage

// File: rtl/cnt_digit.sv
// One modulo-MODULUS up/down digit with clamped parallel load and a flag that
// marks the digit sitting at its terminal value for the current direction.
module cnt_digit
   import cnt_pkg::*;
#(
   parameter int DIG_W   = 4,
   parameter int MODULUS = 16
) (
   input  logic             Clk,
   input  logic             MR,
   input  logic             PE,
   input  logic             UP,
   input  logic             i_step,
   input  logic [DIG_W-1:0] i_load,
   output logic [DIG_W-1:0] o_q,
   output logic             o_term
);

   localparam logic [DIG_W-1:0] LP_MAX = DIG_W'(MODULUS - 1);

   logic [DIG_W-1:0] r_q;
   logic [DIG_W-1:0] w_term_val;
   logic [DIG_W-1:0] w_load;

   assign w_term_val = DIG_W'(term_val(UP, MODULUS));
   assign w_load     = (i_load > LP_MAX) ? LP_MAX : i_load;

   always_ff @(posedge Clk or posedge MR) begin
      if (MR) begin
         r_q <= '0;
      end else if (PE) begin
         r_q <= w_load;
      end else if (i_step) begin
         if (UP) begin
            r_q <= (r_q == LP_MAX) ? '0 : r_q + DIG_W'(1);
         end else begin
            r_q <= (r_q == '0) ? LP_MAX : r_q - DIG_W'(1);
         end
      end
   end

   assign o_q    = r_q;
   assign o_term = (r_q == w_term_val);

endmodule

// File: rtl/cnt_cascade.sv
// Multi-digit modulo counter: digits chained through a combinational
// carry/borrow enable, with parallel load and an unregistered terminal count.
module cnt_cascade
   import cnt_pkg::*;
#(
   parameter int DIGITS  = 2,
   parameter int DIG_W   = 4,
   parameter int MODULUS = 16
) (
   input  logic                    Clk,
   input  logic                    MR,
   input  logic                    CE,
   input  logic                    UP,
   input  logic                    PE,
   input  logic [DIGITS*DIG_W-1:0] D,
   output logic [DIGITS*DIG_W-1:0] Q,
   output logic                    C
);

   if (!cfg_legal(DIGITS, DIG_W, MODULUS)) begin : g_bad_cfg
      $error("cnt_cascade: illegal DIGITS/DIG_W/MODULUS combination");
   end

   logic [DIGITS:0]   w_chain;
   logic [DIGITS-1:0] w_term;

   assign w_chain[0] = CE;

   // Digit k steps only when CE is high and every lower digit is terminal.
   for (genvar k = 0; k < DIGITS; k++) begin : g_digit
      cnt_digit #(
         .DIG_W   (DIG_W),
         .MODULUS (MODULUS)
      ) u_digit (
         .Clk    (Clk),
         .MR     (MR),
         .PE     (PE),
         .UP     (UP),
         .i_step (w_chain[k]),
         .i_load (D[k*DIG_W +: DIG_W]),
         .o_q    (Q[k*DIG_W +: DIG_W]),
         .o_term (w_term[k])
      );
      assign w_chain[k+1] = w_chain[k] & w_term[k];
   end

   assign C = w_chain[DIGITS] & ~PE;

endmodule

// File: tb/tb_cnt_cascade.sv
// Directed bench for cnt_cascade: BCD vector table, reset/hold/load corners,
// a 3-digit binary wrap and two chained instances.
module tb_cnt_cascade;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // BCD instance
   logic       b_mr, b_ce, b_up, b_pe;
   logic [7:0] b_d, b_q;
   logic       b_c;

   cnt_cascade #(.DIGITS(2), .DIG_W(4), .MODULUS(10)) u_bcd (
      .Clk(clk), .MR(b_mr), .CE(b_ce), .UP(b_up), .PE(b_pe),
      .D(b_d), .Q(b_q), .C(b_c)
   );

   // 3-digit binary instance
   logic        h_mr, h_ce, h_up, h_pe;
   logic [11:0] h_d, h_q;
   logic        h_c;

   cnt_cascade #(.DIGITS(3), .DIG_W(4), .MODULUS(16)) u_hex (
      .Clk(clk), .MR(h_mr), .CE(h_ce), .UP(h_up), .PE(h_pe),
      .D(h_d), .Q(h_q), .C(h_c)
   );

   // Chained pair: upper CE driven by lower C
   logic       c_mr, c_ce;
   logic [7:0] lo_d, lo_q;
   logic [3:0] hi_d, hi_q;
   logic       lo_c, hi_c;

   cnt_cascade #(.DIGITS(2), .DIG_W(4), .MODULUS(16)) u_lo (
      .Clk(clk), .MR(c_mr), .CE(c_ce), .UP(1'b1), .PE(1'b0),
      .D(lo_d), .Q(lo_q), .C(lo_c)
   );

   cnt_cascade #(.DIGITS(1), .DIG_W(4), .MODULUS(16)) u_hi (
      .Clk(clk), .MR(c_mr), .CE(lo_c), .UP(1'b1), .PE(1'b0),
      .D(hi_d), .Q(hi_q), .C(hi_c)
   );

   typedef struct {
      logic       ce;
      logic       up;
      logic       pe;
      logic [7:0] d;
      logic [7:0] q;
      logic       c;
   } vec_t;

   vec_t vecs[18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic bstep(input logic ce, input logic up, input logic pe, input logic [7:0] d);
      @(negedge clk);
      b_ce = ce;
      b_up = up;
      b_pe = pe;
      b_d  = d;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   logic [11:0] exp_ch;

   initial begin
      n_checks = 0;
      n_fail   = 0;
      b_mr = 1'b1; b_ce = 1'b0; b_up = 1'b1; b_pe = 1'b0; b_d = 8'h00;
      h_mr = 1'b1; h_ce = 1'b0; h_up = 1'b1; h_pe = 1'b0; h_d = 12'h000;
      c_mr = 1'b1; c_ce = 1'b0; lo_d = 8'h00; hi_d = 4'h0;

      vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h01, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h99, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h47, 8'h47, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h3F, 8'h39, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h39, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h40, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h39, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h10, 8'h10, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 8'hFA, 8'h99, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h99, 8'h99, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 8'h98, 8'h98, 1'b0};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h99, 1'b1};
      vecs[17] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0};

      // Reset state, and C from Q=0 while still in reset
      @(negedge clk);
      @(negedge clk);
      chk("rst_q", 32'(b_q), 32'h00);
      chk("rst_c_idle", 32'(b_c), 32'h0);
      b_ce = 1'b1; b_up = 1'b0;
      #1;
      chk("rst_c_down", 32'(b_c), 32'h1);
      b_ce = 1'b0; b_up = 1'b1;
      @(negedge clk);
      b_mr = 1'b0; h_mr = 1'b0; c_mr = 1'b0;

      for (int i = 0; i < 18; i++) begin
         bstep(vecs[i].ce, vecs[i].up, vecs[i].pe, vecs[i].d);
         chk($sformatf("vec%0d_q", i), 32'(b_q), 32'(vecs[i].q));
         chk($sformatf("vec%0d_c", i), 32'(b_c), 32'(vecs[i].c));
      end

      // Count up 99 edges from reset
      @(negedge clk);
      b_mr = 1'b1; b_ce = 1'b0; b_pe = 1'b0;
      @(negedge clk);
      b_mr = 1'b0;
      for (int i = 0; i < 99; i++) bstep(1'b1, 1'b1, 1'b0, 8'h00);
      chk("up99_q", 32'(b_q), 32'h99);
      chk("up99_c", 32'(b_c), 32'h1);
      bstep(1'b1, 1'b1, 1'b0, 8'h00);
      chk("up100_q", 32'(b_q), 32'h00);
      chk("up100_c", 32'(b_c), 32'h0);

      // Asynchronous reset mid-cycle, then resume
      bstep(1'b0, 1'b1, 1'b1, 8'h56);
      chk("mr_pre_q", 32'(b_q), 32'h56);
      #2;
      b_mr = 1'b1;
      #1;
      chk("mr_async_q", 32'(b_q), 32'h00);
      @(posedge clk);
      #1;
      chk("mr_hold_q", 32'(b_q), 32'h00);
      @(negedge clk);
      b_mr = 1'b0; b_ce = 1'b1; b_up = 1'b1; b_pe = 1'b0;
      @(posedge clk);
      #1;
      chk("mr_resume_q", 32'(b_q), 32'h01);

      // Hold at 0x99 with CE low, then raise CE
      bstep(1'b0, 1'b1, 1'b1, 8'h99);
      for (int i = 0; i < 10; i++) begin
         bstep(1'b0, 1'b1, 1'b0, 8'h00);
         chk($sformatf("hold%0d_q", i), 32'(b_q), 32'h99);
         chk($sformatf("hold%0d_c", i), 32'(b_c), 32'h0);
      end
      @(negedge clk);
      b_ce = 1'b1;
      #1;
      chk("hold_ce_c", 32'(b_c), 32'h1);
      chk("hold_ce_q", 32'(b_q), 32'h99);
      b_ce = 1'b0;

      // Three binary digits: full range wrap up, then borrow wrap down
      @(negedge clk);
      h_ce = 1'b1; h_up = 1'b1;
      repeat (4095) @(posedge clk);
      #1;
      chk("hex_fff_q", 32'(h_q), 32'hFFF);
      chk("hex_fff_c", 32'(h_c), 32'h1);
      @(posedge clk);
      #1;
      chk("hex_wrap_q", 32'(h_q), 32'h000);
      chk("hex_wrap_c", 32'(h_c), 32'h0);
      @(negedge clk);
      h_up = 1'b0;
      #1;
      chk("hex_down_c", 32'(h_c), 32'h1);
      @(posedge clk);
      #1;
      chk("hex_down_q", 32'(h_q), 32'hFFF);
      h_ce = 1'b0;

      // Chained instances must produce every value in order
      exp_ch = 12'h000;
      @(negedge clk);
      c_ce = 1'b1;
      for (int i = 0; i < 4098; i++) begin
         @(posedge clk);
         #1;
         exp_ch = exp_ch + 12'h001;
         chk($sformatf("chain%0d", i), 32'({hi_q, lo_q}), 32'(exp_ch));
      end
      c_ce = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
